// File: rtl/mult_datapath_if.sv
`default_nettype none
// ============================================================================
//  Module   : mult_datapath_if
//  Purpose  : Bundles the control/data signals exchanged between the 4-step
//             multiplier control FSM (plus operand source) and the
//             shift-add multiplier datapath.
//  Signals  : start        - operation request, held for the whole operation
//             a_in, b_in   - multiplicand / multiplier
//             sela, selb   - nibble selects (1 = low nibble, 0 = high nibble)
//             sel_shifter  - partial-product shift select
//             done_flag    - FSM is in its FINISH state
//             count        - step counter returned to the FSM (0..4)
//             product      - registered 16-bit result
//             valid        - one-cycle pulse when product updates
//  Modports : master - FSM / operand source side
//             slave  - datapath side
//  Revision : 1.0 - initial release
// ============================================================================
interface mult_datapath_if #(
  parameter int DW = 8,
  parameter int PW = 2 * DW
);
  logic          start;
  logic [DW-1:0] a_in;
  logic [DW-1:0] b_in;
  logic          sela;
  logic          selb;
  logic [1:0]    sel_shifter;
  logic          done_flag;
  logic [2:0]    count;
  logic [PW-1:0] product;
  logic          valid;

  modport master (
    output start, a_in, b_in, sela, selb, sel_shifter, done_flag,
    input  count, product, valid
  );

  modport slave (
    input  start, a_in, b_in, sela, selb, sel_shifter, done_flag,
    output count, product, valid
  );
endinterface : mult_datapath_if
`default_nettype wire

// File: rtl/mult_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : mult_datapath
//  Purpose  : Datapath of the 8x8 unsigned shift-add multiplier. Forms one
//             4x4 nibble partial product per step, shifts it into place,
//             accumulates it over four steps and registers the 16-bit result
//             with a one-cycle valid pulse when the control FSM signals done.
//  Ports    : clk  - system clock, rising edge
//             rst  - asynchronous reset, active low
//             bus  - mult_datapath_if.slave (start, operands, FSM selects,
//                    done_flag in; count, product, valid out)
//  Revision : 1.0 - initial release
// ============================================================================
module mult_datapath #(
  parameter int DW = 8,       // operand width, fixed at 8 (two nibbles)
  parameter int PW = 2 * DW   // product / accumulator width
) (
  input  wire logic       clk,
  input  wire logic       rst,
  mult_datapath_if.slave  bus
);

  localparam int         c_nw      = DW / 2;
  localparam logic [2:0] c_last    = 3'd4;
  localparam logic [1:0] c_sh_0    = 2'b10;
  localparam logic [1:0] c_sh_nib  = 2'b01;
  localparam logic [1:0] c_sh_byte = 2'b00;

  logic [2:0]    r_count;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;
  logic [PW-1:0] r_acc;
  logic [PW-1:0] r_product;
  logic          r_valid;
  logic          r_done_q;

  logic          w_first;
  logic          w_active;
  logic [DW-1:0] w_a_src;
  logic [DW-1:0] w_b_src;
  logic [c_nw-1:0] w_a_nib;
  logic [c_nw-1:0] w_b_nib;
  logic [DW-1:0] w_pp;
  logic [PW-1:0] w_pp_ext;
  logic [PW-1:0] w_pp_sh;

  // First step of an operation: operands are taken straight from the inputs
  // and simultaneously captured for the remaining three steps.
  assign w_first  = bus.start && (r_count == 3'd0);
  // Steps 0..3 contribute; once the counter saturates the partial product is
  // forced to zero so undefined FSM selects in FINISH cannot disturb acc.
  assign w_active = (r_count < c_last);

  assign w_a_src = (r_count == 3'd0) ? bus.a_in : r_a;
  assign w_b_src = (r_count == 3'd0) ? bus.b_in : r_b;
  assign w_a_nib = bus.sela ? w_a_src[c_nw-1:0] : w_a_src[DW-1:c_nw];
  assign w_b_nib = bus.selb ? w_b_src[c_nw-1:0] : w_b_src[DW-1:c_nw];

  // 4x4 unsigned product always fits in 8 bits.
  assign w_pp     = {{c_nw{1'b0}}, w_a_nib} * {{c_nw{1'b0}}, w_b_nib};
  assign w_pp_ext = {{(PW-DW){1'b0}}, w_pp};

  always_comb begin
    w_pp_sh = '0;
    if (w_active) begin
      case (bus.sel_shifter)
        c_sh_0:    w_pp_sh = w_pp_ext;
        c_sh_nib:  w_pp_sh = w_pp_ext << c_nw;
        c_sh_byte: w_pp_sh = w_pp_ext << DW;
        default:   w_pp_sh = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count   <= 3'd0;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_product <= '0;
      r_valid   <= 1'b0;
      r_done_q  <= 1'b0;
    end else begin
      // Step counter mirrors the FSM state; it saturates rather than wraps
      // so a held start cannot launch a second accumulation.
      if (!bus.start) begin
        r_count <= 3'd0;
      end else if (r_count != c_last) begin
        r_count <= r_count + 3'd1;
      end

      if (w_first) begin
        r_a   <= bus.a_in;
        r_b   <= bus.b_in;
        r_acc <= w_pp_sh;
      end else if (bus.start && w_active) begin
        r_acc <= r_acc + w_pp_sh;
      end

      // Result is captured on the rising edge of done_flag only, giving
      // exactly one valid pulse per completed operation.
      r_done_q <= bus.done_flag;
      if (bus.done_flag && !r_done_q) begin
        r_product <= r_acc;
        r_valid   <= 1'b1;
      end else begin
        r_valid   <= 1'b0;
      end
    end
  end

  assign bus.count   = r_count;
  assign bus.product = r_product;
  assign bus.valid   = r_valid;

endmodule : mult_datapath
`default_nettype wire

// File: tb/tb_mult_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_datapath
//  Purpose  : Self-checking bench for mult_datapath. Contains a behavioural
//             stand-in for the 4-step control FSM, a product-level reference
//             model (product = a * b of the captured operands) and directed
//             operations with hand-computed results.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mult_datapath;

  logic clk;
  logic rst_n;

  int vectors;
  int fails;
  int pulses;

  mult_datapath_if #(.DW(8), .PW(16)) bus ();

  mult_datapath #(.DW(8), .PW(16)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Control FSM stand-in: S0..S3 then FINISH (4), back to S0 when start drops.
  // --------------------------------------------------------------------------
  logic [2:0] fsm_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                fsm_state <= 3'd0;
    else if (!bus.start)       fsm_state <= 3'd0;
    else if (fsm_state < 3'd4) fsm_state <= fsm_state + 3'd1;
  end

  always_comb begin
    bus.sela        = 1'b1;
    bus.selb        = 1'b1;
    bus.sel_shifter = 2'b11;
    bus.done_flag   = 1'b0;
    case (fsm_state)
      3'd0: begin bus.sela = 1'b1; bus.selb = 1'b1; bus.sel_shifter = 2'b10; end
      3'd1: begin bus.sela = 1'b1; bus.selb = 1'b0; bus.sel_shifter = 2'b01; end
      3'd2: begin bus.sela = 1'b0; bus.selb = 1'b1; bus.sel_shifter = 2'b01; end
      3'd3: begin bus.sela = 1'b0; bus.selb = 1'b0; bus.sel_shifter = 2'b00; end
      default: bus.done_flag = 1'b1;
    endcase
  end

  // --------------------------------------------------------------------------
  // Reference model: operands latched on the first step, result is their
  // arithmetic product, published once on the rising edge of done_flag.
  // --------------------------------------------------------------------------
  logic [7:0]  m_a, m_b;
  logic [15:0] m_product;
  logic        m_valid;
  logic        m_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a <= '0; m_b <= '0; m_product <= '0; m_valid <= 1'b0; m_done_q <= 1'b0;
    end else begin
      if (bus.start && fsm_state == 3'd0) begin
        m_a <= bus.a_in;
        m_b <= bus.b_in;
      end
      m_done_q <= bus.done_flag;
      m_valid  <= bus.done_flag && !m_done_q;
      if (bus.done_flag && !m_done_q) m_product <= 16'(m_a) * 16'(m_b);
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("cyc_count",   16'(bus.count), 16'(fsm_state));
    chk("cyc_valid",   16'(bus.valid), 16'(m_valid));
    chk("cyc_product", bus.product,    m_product);
    if (bus.valid === 1'b1) pulses++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Full operation with start held through completion plus `hold` extra
  // cycles, then one cycle of start low.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input int hold, input bit chg);
    int p0;
    p0 = pulses;
    bus.a_in  = a;
    bus.b_in  = b;
    bus.start = 1'b1;
    chk("step0_count", 16'(bus.count), 16'd0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (chg && k == 1) begin
        bus.a_in = 8'h99;
        bus.b_in = 8'h77;
      end
      chk("step_count", 16'(bus.count), 16'(k));
      chk("step_valid", 16'(bus.valid), 16'd0);
    end
    tick();
    chk("e5_valid",   16'(bus.valid), 16'd1);
    chk("e5_product", bus.product,    exp);
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("hold_valid", 16'(bus.valid), 16'd0);
    end
    chk("hold_count", 16'(bus.count), 16'd4);
    chk("pulse_once", 16'(pulses - p0), 16'd1);
    bus.start = 1'b0;
    tick();
    chk("idle_count", 16'(bus.count), 16'd0);
  endtask

  initial begin
    vectors   = 0;
    fails     = 0;
    pulses    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;

    #1;
    chk("rst_count",   16'(bus.count), 16'd0);
    chk("rst_product", bus.product,    16'h0000);
    chk("rst_valid",   16'(bus.valid), 16'd0);
    tick();
    rst_n = 1'b1;
    tick();

    run_op(8'h12, 8'h34, 16'h03A8, 1, 1'b0);
    run_op(8'hFF, 8'hFF, 16'hFE01, 1, 1'b0);
    chk("model_ff", m_product, 16'hFE01);
    run_op(8'h12, 8'h34, 16'h03A8, 1, 1'b1);

    // Abort after two steps: counter clears, no pulse, product untouched.
    begin
      int p0;
      p0 = pulses;
      bus.a_in  = 8'h12;
      bus.b_in  = 8'h34;
      bus.start = 1'b1;
      tick();
      tick();
      bus.start = 1'b0;
      tick();
      chk("abort_count",   16'(bus.count), 16'd0);
      chk("abort_valid",   16'(bus.valid), 16'd0);
      chk("abort_product", bus.product,    16'h03A8);
      tick();
      tick();
      chk("abort_pulse", 16'(pulses - p0), 16'd0);
    end
    run_op(8'h0F, 8'hF0, 16'h0E10, 1, 1'b0);

    run_op(8'hAB, 8'hCD, 16'h88EF, 20, 1'b0);
    chk("model_abcd", m_product, 16'h88EF);
    run_op(8'h00, 8'h5A, 16'h0000, 1, 1'b0);
    run_op(8'h12, 8'h34, 16'h03A8, 1, 1'b0);

    // Reset mid-operation at step 3.
    begin
      int p0;
      p0 = pulses;
      bus.a_in  = 8'hAB;
      bus.b_in  = 8'hCD;
      bus.start = 1'b1;
      tick();
      tick();
      tick();
      chk("pre_rst_count", 16'(bus.count), 16'd3);
      rst_n = 1'b0;
      #1;
      chk("arst_count",   16'(bus.count), 16'd0);
      chk("arst_product", bus.product,    16'h0000);
      chk("arst_valid",   16'(bus.valid), 16'd0);
      bus.start = 1'b0;
      #3;
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
        tick();
        chk("post_rst_count",   16'(bus.count), 16'd0);
        chk("post_rst_valid",   16'(bus.valid), 16'd0);
        chk("post_rst_product", bus.product,    16'h0000);
      end
      chk("post_rst_pulse", 16'(pulses - p0), 16'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule : tb_mult_datapath
`default_nettype wire
